// File: rtl/bw_mul_seq.sv
// bw_mul_seq: sequential Baugh-Wooley multiplier.
// Accumulates one partial-product row per clock into a 2*WIDTH-bit
// accumulator. Handles unsigned operands and, at runtime, two's-complement
// operands. Valid/ready handshakes on the operand and product sides.
// Optional feature macro: BW_MUL_SAT_EN adds the p_sat / sat_flag outputs,
// which carry the product saturated to WIDTH bits.
module bw_mul_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic               signed_mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] p
`ifdef BW_MUL_SAT_EN
   ,
   output logic [WIDTH-1:0]   p_sat,
   output logic               sat_flag
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Baugh-Wooley correction constant: 2^WIDTH + 2^(2*WIDTH-1).
   localparam logic [2*WIDTH-1:0] BW_CONST =
      {1'b1, {(WIDTH-2){1'b0}}, 1'b1, {WIDTH{1'b0}}};

   state_t               state_r;
   logic [CNT_W-1:0]     cnt_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]     a_r;
   logic [WIDTH-1:0]     b_r;
   logic                 mode_r;
   logic                 in_ready_r;
   logic                 out_valid_r;
   logic [2*WIDTH-1:0]   p_r;

   logic                 last_row_s;
   logic [WIDTH-1:0]     row_bits_s;
   logic [2*WIDTH-1:0]   pp_s;
   logic [2*WIDTH-1:0]   const_s;
   logic [2*WIDTH-1:0]   acc_next_s;

`ifdef BW_MUL_SAT_EN
   logic [WIDTH-1:0]     p_sat_r;
   logic                 sat_flag_r;
   logic [WIDTH:0]       sat_s;

   // Saturate a full product to WIDTH bits; returns {clamped, value}.
   function automatic logic [WIDTH:0] sat_fn(input logic [2*WIDTH-1:0] prod,
                                             input logic sgn);
      logic [WIDTH:0] res;
      if (sgn) begin
         // The product fits when its top WIDTH+1 bits are a pure sign extension.
         if ((prod[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b0}}) ||
             (prod[2*WIDTH-1:WIDTH-1] == {(WIDTH+1){1'b1}})) begin
            res = {1'b0, prod[WIDTH-1:0]};
         end else if (prod[2*WIDTH-1]) begin
            res = {1'b1, 1'b1, {(WIDTH-1){1'b0}}};
         end else begin
            res = {1'b1, 1'b0, {(WIDTH-1){1'b1}}};
         end
      end else begin
         if (prod[2*WIDTH-1:WIDTH] == {WIDTH{1'b0}}) begin
            res = {1'b0, prod[WIDTH-1:0]};
         end else begin
            res = {1'b1, {WIDTH{1'b1}}};
         end
      end
      return res;
   endfunction

   // Saturation of the value about to be published as the product.
   always_comb begin
      sat_s = sat_fn(acc_next_s, mode_r);
   end

   assign p_sat    = p_sat_r;
   assign sat_flag = sat_flag_r;
`endif

   // Build partial-product row cnt_r and the next accumulator value.
   always_comb begin
      last_row_s = (cnt_r == CNT_W'(WIDTH-1));
      row_bits_s = {WIDTH{1'b0}};
      // In signed mode only the terms touching exactly one operand's
      // sign bit (column or row WIDTH-1, but not both) are inverted.
      for (int i = 0; i < WIDTH; i++) begin
         row_bits_s[i] = (a_r[i] & b_r[cnt_r]) ^
                         (mode_r & ((i == WIDTH-1) ^ last_row_s));
      end
      pp_s = {{WIDTH{1'b0}}, row_bits_s} << cnt_r;
      if (mode_r && (cnt_r == {CNT_W{1'b0}})) begin
         const_s = BW_CONST;
      end else begin
         const_s = {(2*WIDTH){1'b0}};
      end
      // Carries out of the top bit are dropped: the sum is modulo 2^(2*WIDTH).
      acc_next_s = acc_r + pp_s + const_s;
   end

   // Control FSM, operand capture, row accumulation and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         cnt_r       <= {CNT_W{1'b0}};
         acc_r       <= {(2*WIDTH){1'b0}};
         a_r         <= {WIDTH{1'b0}};
         b_r         <= {WIDTH{1'b0}};
         mode_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         p_r         <= {(2*WIDTH){1'b0}};
`ifdef BW_MUL_SAT_EN
         p_sat_r     <= {WIDTH{1'b0}};
         sat_flag_r  <= 1'b0;
`endif
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid && in_ready_r) begin
                  a_r        <= a;
                  b_r        <= b;
                  mode_r     <= signed_mode;
                  acc_r      <= {(2*WIDTH){1'b0}};
                  cnt_r      <= {CNT_W{1'b0}};
                  in_ready_r <= 1'b0;
                  state_r    <= BUSY;
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            BUSY: begin
               acc_r <= acc_next_s;
               if (last_row_s) begin
                  p_r         <= acc_next_s;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
`ifdef BW_MUL_SAT_EN
                  p_sat_r     <= sat_s[WIDTH-1:0];
                  sat_flag_r  <= sat_s[WIDTH];
`endif
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            DONE: begin
               // The product is held until the consumer takes it; a new
               // operand can only be accepted from the following IDLE cycle.
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
`ifdef BW_MUL_SAT_EN
                  sat_flag_r  <= 1'b0;
`endif
               end else begin
                  out_valid_r <= 1'b1;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign p         = p_r;

endmodule

// File: tb/tb_bw_mul_seq.sv
// Directed self-checking bench for bw_mul_seq (WIDTH=8 and WIDTH=4 instances).
module tb_bw_mul_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, signed_mode, out_valid, out_ready;
   logic [7:0]  a, b;
   logic [15:0] p;

   logic        in_valid4, in_ready4, mode4, out_valid4, out_ready4;
   logic [3:0]  a4, b4;
   logic [7:0]  p4;

`ifdef BW_MUL_SAT_EN
   logic [7:0]  p_sat;
   logic        sat_flag;
   logic [3:0]  p_sat4;
   logic        sat_flag4;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   bw_mul_seq #(.WIDTH(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid),
      .out_ready(out_ready), .p(p)
`ifdef BW_MUL_SAT_EN
      , .p_sat(p_sat), .sat_flag(sat_flag)
`endif
   );

   bw_mul_seq #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .signed_mode(mode4), .out_valid(out_valid4),
      .out_ready(out_ready4), .p(p4)
`ifdef BW_MUL_SAT_EN
      , .p_sat(p_sat4), .sat_flag(sat_flag4)
`endif
   );

   // Present operands and return at the negedge after the accept edge.
   task automatic start_op(input logic [7:0] ta, input logic [7:0] tb, input logic tm);
      int n;
      @(negedge clk);
      a = ta; b = tb; signed_mode = tm; in_valid = 1'b1; out_ready = 1'b0;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Count edges until out_valid; -1 on timeout. Optionally scramble inputs.
   task automatic wait_done(input logic scramble, output int lat);
      lat = 0;
      while (!out_valid && lat < 64) begin
         if (scramble) begin
            a = 8'($urandom_range(255, 0));
            b = 8'($urandom_range(255, 0));
            signed_mode = 1'($urandom_range(1, 0));
            in_valid = 1'b1;
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      if (!out_valid) lat = -1;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (p !== 16'h0000) begin errors++; $display("FAIL reset_p got=%h exp=0000", p); end
      checks++; if (in_ready4 !== 1'b0) begin errors++; $display("FAIL reset_in_ready4 got=%b exp=0", in_ready4); end
`ifdef BW_MUL_SAT_EN
      checks++; if ({p_sat, sat_flag} !== 9'h000) begin errors++; $display("FAIL reset_sat got=%h/%b exp=00/0", p_sat, sat_flag); end
`endif
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
   endtask

   task automatic test_signed();
      logic [7:0]  va [8] = '{8'h80, 8'h80, 8'hFF, 8'h7F, 8'h00, 8'hFE, 8'h7F, 8'h01};
      logic [7:0]  vb [8] = '{8'h80, 8'h7F, 8'h01, 8'h7F, 8'h85, 8'h03, 8'h80, 8'h80};
      logic [15:0] vp [8] = '{16'h4000, 16'hC080, 16'hFFFF, 16'h3F01,
                              16'h0000, 16'hFFFA, 16'hC080, 16'hFF80};
      int lat;
      for (int i = 0; i < 8; i++) begin
         start_op(va[i], vb[i], 1'b1);
         wait_done(1'b0, lat);
         checks++; if (lat !== 8) begin errors++; $display("FAIL signed_latency[%0d] got=%0d exp=8", i, lat); end
         checks++; if (p !== vp[i]) begin errors++; $display("FAIL signed_p[%0d] got=%h exp=%h", i, p, vp[i]); end
         handshake();
      end
   endtask

   task automatic test_unsigned();
      logic [7:0]  va [7] = '{8'hFF, 8'h80, 8'h0F, 8'h12, 8'h00, 8'hFF, 8'hAA};
      logic [7:0]  vb [7] = '{8'hFF, 8'h80, 8'h11, 8'h34, 8'hFF, 8'h01, 8'h55};
      logic [15:0] vp [7] = '{16'hFE01, 16'h4000, 16'h00FF, 16'h03A8,
                              16'h0000, 16'h00FF, 16'h3872};
      int lat;
      for (int i = 0; i < 7; i++) begin
         start_op(va[i], vb[i], 1'b0);
         wait_done(1'b0, lat);
         checks++; if (lat !== 8) begin errors++; $display("FAIL unsigned_latency[%0d] got=%0d exp=8", i, lat); end
         checks++; if (p !== vp[i]) begin errors++; $display("FAIL unsigned_p[%0d] got=%h exp=%h", i, p, vp[i]); end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      start_op(8'h12, 8'h34, 1'b0);
      wait_done(1'b1, lat);
      checks++; if (p !== 16'h03A8) begin errors++; $display("FAIL isolation_p got=%h exp=03A8", p); end
      for (int i = 0; i < 5; i++) begin
         a = 8'($urandom_range(255, 0));
         in_valid = 1'b1;
         @(negedge clk);
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
         checks++; if (p !== 16'h03A8) begin errors++; $display("FAIL bp_p[%0d] got=%h exp=03A8", i, p); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      end
      in_valid = 1'b0;
      handshake();
   endtask

   task automatic test_back_to_back();
      int lat;
      start_op(8'h03, 8'h05, 1'b0);
      wait_done(1'b0, lat);
      checks++; if (p !== 16'h000F) begin errors++; $display("FAIL b2b_first_p got=%h exp=000F", p); end
      // New operand offered together with out_ready in DONE.
      a = 8'h07; b = 8'h09; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_out_valid got=%b exp=0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_idle_in_ready got=%b exp=1", in_ready); end
      @(negedge clk);
      in_valid = 1'b0;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_accept got=%b exp=0", in_ready); end
      wait_done(1'b0, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL b2b_latency got=%0d exp=8", lat); end
      checks++; if (p !== 16'h003F) begin errors++; $display("FAIL b2b_second_p got=%h exp=003F", p); end
      handshake();
   endtask

   task automatic test_reset_midop();
      int lat;
      start_op(8'hFF, 8'hFF, 1'b0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
      checks++; if (p !== 16'h0000) begin errors++; $display("FAIL midrst_p got=%h exp=0000", p); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
      @(negedge clk);
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_idle got=%b exp=1", in_ready); end
      repeat (10) @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_output got=%b exp=0", out_valid); end
      start_op(8'h03, 8'h05, 1'b0);
      wait_done(1'b0, lat);
      checks++; if (lat !== 8) begin errors++; $display("FAIL midrst_next_latency got=%0d exp=8", lat); end
      checks++; if (p !== 16'h000F) begin errors++; $display("FAIL midrst_next_p got=%h exp=000F", p); end
      handshake();
   endtask

   task automatic test_width4();
      logic [3:0] va [3] = '{4'h8, 4'hF, 4'h7};
      logic [3:0] vb [3] = '{4'h8, 4'hF, 4'h9};
      logic       vm [3] = '{1'b1, 1'b0, 1'b1};
      logic [7:0] vp [3] = '{8'h40, 8'hE1, 8'hCF};
      int n;
      int lat;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         a4 = va[i]; b4 = vb[i]; mode4 = vm[i]; in_valid4 = 1'b1; out_ready4 = 1'b0;
         n = 0;
         while (!in_ready4 && n < 50) begin
            @(negedge clk);
            n++;
         end
         @(posedge clk);
         @(negedge clk);
         in_valid4 = 1'b0;
         lat = 0;
         while (!out_valid4 && lat < 64) begin
            @(negedge clk);
            lat++;
         end
         checks++; if (lat !== 4) begin errors++; $display("FAIL w4_latency[%0d] got=%0d exp=4", i, lat); end
         checks++; if (p4 !== vp[i]) begin errors++; $display("FAIL w4_p[%0d] got=%h exp=%h", i, p4, vp[i]); end
         out_ready4 = 1'b1;
         @(negedge clk);
         out_ready4 = 1'b0;
      end
   endtask

`ifdef BW_MUL_SAT_EN
   task automatic test_sat();
      logic [7:0] va [5] = '{8'd100, 8'h80, 8'd16, 8'd3, 8'h80};
      logic [7:0] vb [5] = '{8'd100, 8'h01, 8'd16, 8'd5, 8'hFF};
      logic       vm [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      logic [7:0] vs [5] = '{8'h7F, 8'h80, 8'hFF, 8'h0F, 8'h7F};
      logic       vf [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      int lat;
      for (int i = 0; i < 5; i++) begin
         start_op(va[i], vb[i], vm[i]);
         wait_done(1'b0, lat);
         checks++; if (p_sat !== vs[i]) begin errors++; $display("FAIL sat_value[%0d] got=%h exp=%h", i, p_sat, vs[i]); end
         checks++; if (sat_flag !== vf[i]) begin errors++; $display("FAIL sat_flag[%0d] got=%b exp=%b", i, sat_flag, vf[i]); end
         handshake();
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; a = 8'h00; b = 8'h00; signed_mode = 1'b0;
      in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = 4'h0; b4 = 4'h0; mode4 = 1'b0;
      test_reset();
      test_signed();
      test_unsigned();
      test_backpressure();
      test_back_to_back();
      test_reset_midop();
      test_width4();
`ifdef BW_MUL_SAT_EN
      test_sat();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bw_mul_seq.md
Name: bw_mul_seq

Overview:
Parametrised, sequential Baugh-Wooley multiplier. It succeeds the 8x8 combinational array with:
- generic operand width;
- runtime signed/unsigned mode;
- full 2*WIDTH-bit product;
- valid/ready handshakes on input and output.

It accumulates one partial-product row per clock, trading latency for area. It sits between a request source (e.g. a Wishbone-side register block) and a result consumer.

Parameters:
WIDTH, 8, operand width in bits; legal range 4..32.
CNT_W, $clog2(WIDTH), width of the row counter; derived, do not override.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  synchronous reset, active low.
in_valid  input  1  operands present.
in_ready  output  1  block can accept operands.
a  input  WIDTH  multiplicand.
b  input  WIDTH  multiplier.
signed_mode  input  1  1 = two's-complement operands; 0 = unsigned.
out_valid  output  1  product valid.
out_ready  input  1  consumer accepts product.
p  output  2*WIDTH  full product.

Behaviour:
- Reset: one clock, synchronous active-low reset. On a clk edge with rst_n=0:
  - state=IDLE, row counter=0, accumulator=0, p=0, out_valid=0;
  - captured operands and mode cleared.
  - in_ready is 0 while rst_n=0 and 1 from the first cycle after release.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture a, b and signed_mode; clear accumulator; cnt=0; go to BUSY.
  - BUSY: in_ready=0. Each cycle add partial-product row cnt into the accumulator; cnt++. When cnt==WIDTH-1, the last row is added and the state goes to DONE.
  - DONE: out_valid=1, p = accumulator. Hold p stable until out_valid&&out_ready, then go to IDLE.
- Latency: out_valid is asserted exactly WIDTH cycles after the accept edge. For WIDTH=8, accept on edge 0 gives out_valid high after edge 8.
- Throughput: one result per WIDTH+2 cycles with out_ready held high. No overlap of consecutive operations.
- Input-change isolation: changes on a, b or signed_mode while BUSY or DONE have no effect. in_valid is ignored outside IDLE.
- Unsigned mode: p = a*b, exact, 2*WIDTH bits.
- Signed mode: Baugh-Wooley partial products.
  - Terms a[i]b[j] for i,j<N-1, and a[N-1]b[N-1], are taken as-is.
  - Terms a[N-1]b[j] and a[i]b[N-1] for i,j<N-1 are inverted.
  - Constant 2^N + 2^(2N-1) is added.
  - Sum taken modulo 2^(2N), where N=WIDTH.
  - Result must equal the exact two's-complement product.
  - Inverted terms are inserted only in rows/columns N-1; the constant is added with row 0.
- Accumulator: 2*WIDTH bits; intermediate carries out of bit 2N-1 are discarded.
- Reset mid-operation: an operation in BUSY or DONE is abandoned with no output. The first post-reset accept starts cleanly.
- Simultaneous in_valid with out_ready in DONE: the new operand is not accepted that cycle. It is accepted the following cycle in IDLE.

Optional Feature:
Macro BW_MUL_SAT_EN.
- Defined:
  - Adds output port p_sat, WIDTH bits, valid when out_valid=1.
  - p_sat is the product saturated to WIDTH bits:
    - signed mode: clamp to [-2^(N-1), 2^(N-1)-1];
    - unsigned mode: clamp to 2^N-1.
  - Adds output port sat_flag, 1 bit, high with out_valid when clamping occurred.
  - Both ports reset to 0.
- Undefined: neither port exists; behaviour of all other ports is identical.

Test Plan:
1. WIDTH=8, signed: a=0x80, b=0x80 -> out_valid after 8 cycles, p=0x4000. Then a=0x80, b=0x7F -> p=0xC080. Then a=0xFF, b=0x01 -> p=0xFFFF.
2. WIDTH=8, unsigned: a=0xFF, b=0xFF -> p=0xFE01. Exhaustive sweep of all 65536 pairs in both modes against a reference model -> zero mismatches.
3. Backpressure: out_ready=0 for 5 cycles after out_valid -> p stable, in_ready=0 throughout. Operands changed during BUSY are not reflected in p.
4. Reset mid-op: assert rst_n=0 for one cycle at cnt=3 -> next cycle out_valid=0, p=0, state IDLE. Next op 3*5 -> p=15.
5. WIDTH=4 and WIDTH=16 builds, signed: -8*-8 -> 0x40, latency 4. 0x8000*0x8000 -> 0x40000000, latency 16.
6. BW_MUL_SAT_EN, WIDTH=8, signed: 100*100 -> p_sat=0x7F, sat_flag=1. -128*1 -> p_sat=0x80, sat_flag=0. Unsigned 16*16 -> p_sat=0xFF, sat_flag=1.
